booth_product_accumulator: RTL and testbench
============================================

# booth_product_accumulator

Downstream consumer of the 4-bit signed Booth multiplier. It detects each completed multiplication from the multiplier's level-style `ready`, captures the 8-bit signed product, and accumulates LEN products into a saturating signed sum (a dot-product stage). It presents the sum with a valid/ack handshake and buffers one early product while a result waits to be taken.

## Interface
- `ACC_W`, 12: accumulator and result width in bits. Legal range 8..32.
- `LEN`, 4: number of products per result. Legal range 2..15.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset (fixed).
- `clear`  in  1  synchronous abort. Highest priority after `reset`.
- `mul_product`  in  8  signed two's-complement product from the multiplier.
- `mul_ready`  in  1  multiplier ready level. Stays high from completion until the next start.
- `acc_out`  out  ACC_W  signed accumulated result.
- `acc_valid`  out  1  `acc_out` holds a completed result.
- `acc_ack`  in  1  consumer takes the result. Effective only while `acc_valid`=1.
- `overflow`  out  1  saturation occurred within the current or held accumulation.
- `dropped`  out  1  sticky flag: a product was lost. Cleared by `reset`/`clear` only.
- `busy`  out  1  count ≠ 0 or `acc_valid`=1.

## Operation
- Edge detect: `rdy_d` is a register of `mul_ready`, reset to 0. A new product is signalled by `new_p = mul_ready & ~rdy_d`. `mul_product` is sampled in the `new_p` cycle.
  - A `mul_ready` level held high for any number of cycles counts as exactly one product.
- Width rule: the product is sign-extended to ACC_W before it is added.
- Saturation: if the true sum exceeds 2^(ACC_W-1)-1 or is below -2^(ACC_W-1):
  - the accumulator clamps to that bound and `overflow` sets;
  - later additions start from the clamped value.
- Internal state: accumulator `acc`, a count 0..LEN-1, and a one-entry buffer (`buf`, `buf_full`).
- State ACCUM (`acc_valid`=0):
  - On `new_p`: `acc` <= sat(`acc` + sext(product)) and count increments.
  - When this addition is the LEN-th: count <= 0, `acc_valid` <= 1, go to DONE.
- State DONE (`acc_valid`=1; `acc_out` and `overflow` stay stable):
  - `new_p` with `buf_full`=0: product goes to `buf` and `buf_full` <= 1.
  - `new_p` with `buf_full`=1: product is discarded and `dropped` <= 1.
  - `acc_ack` with `buf_full`=0: `acc` <= 0, count <= 0, `overflow` <= 0, go to ACCUM.
  - `acc_ack` with `buf_full`=1: `acc` <= sext(`buf`), count <= 1, `overflow` <= 0, `buf_full` <= 0, go to ACCUM.
- Simultaneous `acc_ack` and `new_p` in DONE:
  - `buf_full`=0: `acc` <= sext(new product), count <= 1.
  - `buf_full`=1: `acc` <= sext(`buf`), count <= 1, and `buf` <= new product with `buf_full` staying 1. Nothing is dropped.
- `clear`: state ACCUM; `acc`, count, `overflow`, `dropped`, `buf_full`, `acc_valid` all go to 0. Any `new_p` in the same cycle is ignored. `rdy_d` still updates.
- `acc_out` is driven from `acc` at all times.

## Timing
- Reset values: `acc_out`=0, `acc_valid`=0, `overflow`=0, `dropped`=0, `busy`=0. Internally count=0, `buf_full`=0, `rdy_d`=0, state ACCUM.
- Reset is asynchronous: outputs reach reset values without waiting for a clock edge, including in the middle of an accumulation or while DONE. Reset release takes effect at the next rising edge.
- Latency:
  - `mul_ready` rising at edge N gives `new_p` in cycle N; `acc` updates at edge N+1.
  - For the LEN-th product, `acc_valid` rises at edge N+1 together with the final `acc_out`.
- Handshake: `acc_valid` holds until the edge at which `acc_ack`=1 is sampled and falls on that edge. `acc_ack` while `acc_valid`=0 is ignored.
- Back-to-back throughput: one product per cycle in the edge detector. The multiplier itself delivers at most one product every 10 cycles.

## Test plan
- Basic accumulation (LEN=4, ACC_W=12): products 15, -14 (0xF2), 8, 1, each `ready` held 3 cycles → `acc_out`=10, `acc_valid`=1 one cycle after the 4th rising edge, `overflow`=0, `busy`=1.
- Saturation (ACC_W=8): products 64, 64, -8, 1 → after the 2nd, `acc`=127 and `overflow`=1. Final `acc_out`=120 (127-8+1), `overflow`=1. After ack, `overflow`=0 and `acc`=0.
- Level vs edge: `mul_ready` held high 20 cycles with product 0x07, then low, then high again with 0x02 → exactly 2 terms counted, `acc`=9, count=2.
- Buffer and drop: the result is held unacked while products 5 and 6 arrive → `buf`=5, 6 discarded, `dropped`=1. Ack → `acc`=5, count=1, `acc_valid`=0. `dropped` stays 1 until `clear`.
- Ack collision: in DONE with `buf`=3, ack in the same cycle as a new product 4 → `acc`=3, count=1, `buf`=4, `buf_full`=1, `dropped`=0.
- Reset/clear mid-operation: after 2 terms (`acc`=20), assert `reset` between clock edges → `acc_out`=0 immediately. Repeat using `clear` → zeros at the next edge, and a `new_p` in the clear cycle is not counted.

Source files
------------

// File: rtl/booth_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : booth_product_accumulator
//  Purpose  : Downstream consumer of a 4-bit signed Booth multiplier.
//             Detects each completed multiplication from the level-style
//             mul_ready, sign-extends the 8-bit product and accumulates LEN
//             products into a saturating signed sum (dot-product stage).
//             The finished sum is offered on a valid/ack handshake; one
//             product arriving while a result waits is held in a one-entry
//             buffer, further ones are dropped and flagged.
//  Ports    :
//    clk          in   rising-edge clock
//    reset        in   asynchronous active-high reset
//    clear        in   synchronous abort (highest priority after reset)
//    mul_product  in   [7:0] signed product from the multiplier
//    mul_ready    in   multiplier ready level (one product per rising edge)
//    acc_out      out  [ACC_W-1:0] signed accumulated result
//    acc_valid    out  acc_out holds a completed result
//    acc_ack      in   consumer takes the result (only while acc_valid)
//    overflow     out  saturation occurred in the current/held accumulation
//    dropped      out  sticky: a product was lost
//    busy         out  accumulation in progress or result pending
//  Revision : 1.0  initial release
// ============================================================================
module booth_product_accumulator #(
  parameter int ACC_W = 12,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [7:0]       mul_product,
  input  logic             mul_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ack,
  output logic             overflow,
  output logic             dropped,
  output logic             busy
);

  // LEN is at most 15, so four bits always hold count 0..LEN-1.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic [7:0]              prod_buf;
  logic                    buf_full;
  logic                    rdy_d;

  logic                    new_p;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] buf_ext;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_sat;
  logic                    sum_ovf;

  // Sign-extension happens through assignment of a signed 8-bit value to a
  // wider signed result; this also covers ACC_W == 8 without a zero-width
  // replication.
  function automatic logic signed [ACC_W-1:0] sext8(input logic signed [7:0] v);
    return v;
  endfunction

  // A held-high ready level must count as exactly one product.
  assign new_p    = mul_ready & ~rdy_d;
  assign prod_ext = sext8(mul_product);
  assign buf_ext  = sext8(prod_buf);

  // One guard bit is enough to see any overflow of a single addition; the
  // two top bits disagree exactly when the true sum leaves the ACC_W range.
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    sum_ovf  = 1'b0;
    sum_sat  = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W:ACC_W-1] == 2'b01) begin
      sum_ovf = 1'b1;
      sum_sat = ACC_MAX;
    end else if (sum_wide[ACC_W:ACC_W-1] == 2'b10) begin
      sum_ovf = 1'b1;
      sum_sat = ACC_MIN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      prod_buf  <= '0;
      buf_full  <= 1'b0;
      rdy_d     <= 1'b0;
      acc_valid <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      // The edge detector keeps tracking even during clear, so a ready
      // level that is already high after the abort is not recounted.
      rdy_d <= mul_ready;

      if (clear) begin
        state     <= ACCUM;
        acc       <= '0;
        count     <= '0;
        buf_full  <= 1'b0;
        acc_valid <= 1'b0;
        overflow  <= 1'b0;
        dropped   <= 1'b0;
      end else begin
        case (state)
          ACCUM: begin
            if (new_p) begin
              acc <= sum_sat;
              if (sum_ovf) begin
                overflow <= 1'b1;
              end
              if (count == CNT_LAST) begin
                count     <= '0;
                acc_valid <= 1'b1;
                state     <= DONE;
              end else begin
                count <= count + CNT_ONE;
              end
            end
          end

          DONE: begin
            if (acc_ack) begin
              // Result taken: start the next accumulation, seeding it with
              // the oldest pending product so arrival order is preserved.
              state     <= ACCUM;
              acc_valid <= 1'b0;
              overflow  <= 1'b0;
              if (buf_full) begin
                acc   <= buf_ext;
                count <= CNT_ONE;
                if (new_p) begin
                  prod_buf <= mul_product;
                end else begin
                  buf_full <= 1'b0;
                end
              end else if (new_p) begin
                acc   <= prod_ext;
                count <= CNT_ONE;
              end else begin
                acc   <= '0;
                count <= '0;
              end
            end else if (new_p) begin
              if (buf_full) begin
                dropped <= 1'b1;
              end else begin
                prod_buf <= mul_product;
                buf_full <= 1'b1;
              end
            end
          end

          default: begin
            state <= ACCUM;
          end
        endcase
      end
    end
  end

  assign acc_out = acc;
  assign busy    = (count != '0) | acc_valid;

endmodule
`default_nettype wire

// File: tb/tb_booth_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_product_accumulator
//  Purpose  : Directed self-checking bench. Two instances share all inputs:
//             dut (ACC_W=12) and dut8 (ACC_W=8), both LEN=4, so the same
//             stimulus shows both normal and saturating behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_product_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [7:0]  mul_product;
  logic        mul_ready;
  logic        acc_ack;

  logic [11:0] acc_out;
  logic        acc_valid, overflow, dropped, busy;
  logic [7:0]  acc_out8;
  logic        acc_valid8, overflow8, dropped8, busy8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_product_accumulator #(.ACC_W(12), .LEN(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .mul_product(mul_product), .mul_ready(mul_ready),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ack(acc_ack),
    .overflow(overflow), .dropped(dropped), .busy(busy)
  );

  booth_product_accumulator #(.ACC_W(8), .LEN(4)) dut8 (
    .clk(clk), .reset(reset), .clear(clear),
    .mul_product(mul_product), .mul_ready(mul_ready),
    .acc_out(acc_out8), .acc_valid(acc_valid8), .acc_ack(acc_ack),
    .overflow(overflow8), .dropped(dropped8), .busy(busy8)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product with ready held for 'hold' cycles, then drop ready.
  task automatic send(input logic [7:0] p, input int hold);
    mul_product = p;
    mul_ready   = 1'b1;
    repeat (hold) tick();
    mul_ready   = 1'b0;
    tick();
  endtask

  task automatic do_ack();
    acc_ack = 1'b1;
    tick();
    acc_ack = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; mul_product = 8'h00; mul_ready = 1'b0; acc_ack = 1'b0;
    #1;
    // Reset state
    check("rst_acc",      int'(acc_out), 0);
    check("rst_valid",    int'(acc_valid), 0);
    check("rst_ovf",      int'(overflow), 0);
    check("rst_dropped",  int'(dropped), 0);
    check("rst_busy",     int'(busy), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Basic accumulation: 15 - 14 + 8 + 1 = 10
    send(8'd15, 3);
    check("basic_acc1",   int'(acc_out), 15);
    check("basic_cnt1",   int'(dut.count), 1);
    send(8'hF2, 3);
    check("basic_acc2",   int'(acc_out), 1);
    send(8'd8, 3);
    check("basic_valid3", int'(acc_valid), 0);
    send(8'd1, 3);
    check("basic_acc",    int'(acc_out), 10);
    check("basic_acc8",   int'(acc_out8), 10);
    check("basic_valid",  int'(acc_valid), 1);
    check("basic_ovf",    int'(overflow), 0);
    check("basic_busy",   int'(busy), 1);
    check("basic_cnt",    int'(dut.count), 0);
    do_ack();
    check("ack_valid",    int'(acc_valid), 0);
    check("ack_acc",      int'(acc_out), 0);
    check("ack_busy",     int'(busy), 0);

    // Saturation on the 8-bit instance: 64 + 64 clamps to 127
    send(8'd64, 1);
    send(8'd64, 1);
    check("sat_acc8_2",   int'(acc_out8), 127);
    check("sat_ovf8_2",   int'(overflow8), 1);
    check("sat_acc12_2",  int'(acc_out), 128);
    check("sat_ovf12_2",  int'(overflow), 0);
    send(8'hF8, 1);
    send(8'd1, 1);
    check("sat_acc8",     int'(acc_out8), 120);
    check("sat_ovf8",     int'(overflow8), 1);
    check("sat_valid8",   int'(acc_valid8), 1);
    check("sat_acc12",    int'(acc_out), 121);
    do_ack();
    check("sat_ack_ovf8", int'(overflow8), 0);
    check("sat_ack_acc8", int'(acc_out8), 0);

    // Level vs edge: a 20-cycle ready level is one product
    mul_product = 8'h07;
    mul_ready   = 1'b1;
    repeat (20) tick();
    mul_ready   = 1'b0;
    tick();
    check("lvl_acc1",     int'(acc_out), 7);
    send(8'h02, 2);
    check("lvl_acc",      int'(acc_out), 9);
    check("lvl_cnt",      int'(dut.count), 2);

    // Buffer and drop while the result (11) is held unacked
    send(8'd1, 1);
    send(8'd1, 1);
    check("buf_valid",    int'(acc_valid), 1);
    send(8'd5, 1);
    send(8'd6, 1);
    check("buf_val",      int'(dut.prod_buf), 5);
    check("buf_full",     int'(dut.buf_full), 1);
    check("buf_dropped",  int'(dropped), 1);
    check("buf_hold_acc", int'(acc_out), 11);
    do_ack();
    check("buf_ack_acc",  int'(acc_out), 5);
    check("buf_ack_cnt",  int'(dut.count), 1);
    check("buf_ack_vld",  int'(acc_valid), 0);
    check("buf_ack_full", int'(dut.buf_full), 0);
    check("drop_sticky",  int'(dropped), 1);
    send(8'd1, 1);
    send(8'd1, 1);
    send(8'd1, 1);
    check("buf_acc_done", int'(acc_out), 8);
    check("drop_sticky2", int'(dropped), 1);
    do_clear();
    check("clr_dropped",  int'(dropped), 0);
    check("clr_valid",    int'(acc_valid), 0);
    check("clr_busy",     int'(busy), 0);

    // Ack collision with a buffered 3 and a new 4
    send(8'd1, 1);
    send(8'd2, 1);
    send(8'd3, 1);
    send(8'd4, 1);
    check("col_result",   int'(acc_out), 10);
    send(8'd3, 1);
    mul_product = 8'd4;
    mul_ready   = 1'b1;
    acc_ack     = 1'b1;
    tick();
    acc_ack     = 1'b0;
    mul_ready   = 1'b0;
    tick();
    check("col_acc",      int'(acc_out), 3);
    check("col_cnt",      int'(dut.count), 1);
    check("col_buf",      int'(dut.prod_buf), 4);
    check("col_full",     int'(dut.buf_full), 1);
    check("col_dropped",  int'(dropped), 0);
    check("col_valid",    int'(acc_valid), 0);

    // Asynchronous reset mid-accumulation
    do_clear();
    send(8'd10, 1);
    send(8'd10, 1);
    check("mid_acc",      int'(acc_out), 20);
    #3;
    reset = 1'b1;
    #1;
    check("arst_acc",     int'(acc_out), 0);
    check("arst_busy",    int'(busy), 0);
    check("arst_cnt",     int'(dut.count), 0);
    reset = 1'b0;
    tick();

    // Clear mid-accumulation; a new_p in the clear cycle is not counted
    send(8'd10, 1);
    send(8'd10, 1);
    check("mid_acc2",     int'(acc_out), 20);
    mul_product = 8'd5;
    mul_ready   = 1'b1;
    clear       = 1'b1;
    tick();
    clear       = 1'b0;
    tick();
    check("clr_acc",      int'(acc_out), 0);
    check("clr_cnt",      int'(dut.count), 0);
    mul_ready   = 1'b0;
    tick();
    check("clr_cnt2",     int'(dut.count), 0);
    send(8'd1, 1);
    check("post_clr_acc", int'(acc_out), 1);
    check("post_clr_cnt", int'(dut.count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
